// File: rtl/hms_clock_core.sv
// Hours/minutes/seconds BCD clock with a run/set-hour/set-minute FSM,
// 12/24-hour display mapping and per-digit blink enables for the set states.
module hms_clock_core #(
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter bit          DEFAULT_12H = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       fmt_btn,
    output logic [3:0] hrs_hi,
    output logic [3:0] hrs_lo,
    output logic [3:0] min_hi,
    output logic [3:0] min_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] sec_lo,
    output logic       pm,
    output logic [1:0] state,
    output logic [5:0] digit_en,
    output logic       sec_tick
);

    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] HALF = CW'(CLK_HZ / 2);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    state_t        st_q, st_nx;
    logic [CW-1:0] presc_q;
    logic [CW-1:0] blink_q, blink_nx;
    logic [3:0]    hrs_hi_q, hrs_lo_q, min_hi_q, min_lo_q, sec_hi_q, sec_lo_q;
    logic          fmt12_q;
    logic          tick;
    logic [8:0]    sec_nx, min_nx;
    logic [7:0]    hrs_nx;
    logic          blink_ph;
    logic [5:0]    en_nx;
    logic          is_pm;

    // {carry, hi, lo} for a BCD field counting 00..59
    function automatic logic [8:0] inc_bcd60(input logic [3:0] hi, input logic [3:0] lo);
        if (lo != 4'd9)
            return {1'b0, hi, lo + 4'd1};
        else if (hi != 4'd5)
            return {1'b0, hi + 4'd1, 4'd0};
        else
            return {1'b1, 4'd0, 4'd0};
    endfunction

    // {hi, lo} for a BCD field counting 00..23
    function automatic logic [7:0] inc_bcd24(input logic [3:0] hi, input logic [3:0] lo);
        if (hi == 4'd2 && lo == 4'd3)
            return 8'h00;
        else if (lo == 4'd9)
            return {hi + 4'd1, 4'd0};
        else
            return {hi, lo + 4'd1};
    endfunction

    // Next-state, increment values and next digit enables
    always_comb begin
        tick   = (st_q == RUN) && (presc_q == TERM);
        sec_nx = inc_bcd60(sec_hi_q, sec_lo_q);
        min_nx = inc_bcd60(min_hi_q, min_lo_q);
        hrs_nx = inc_bcd24(hrs_hi_q, hrs_lo_q);
        st_nx  = st_q;
        case (st_q)
            RUN:     if (mode_btn) st_nx = SET_HR;
            SET_HR:  if (mode_btn) st_nx = SET_MIN;
            SET_MIN: if (mode_btn) st_nx = RUN;
            default: st_nx = RUN;
        endcase
        blink_nx = (blink_q == TERM) ? '0 : blink_q + CW'(1);
        blink_ph = (blink_nx < HALF);
        en_nx    = 6'b111111;
        if (st_nx == SET_HR)
            en_nx[5:4] = {2{blink_ph}};
        else if (st_nx == SET_MIN)
            en_nx[3:2] = {2{blink_ph}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q     <= RUN;
            presc_q  <= '0;
            blink_q  <= '0;
            hrs_hi_q <= 4'd0;
            hrs_lo_q <= 4'd0;
            min_hi_q <= 4'd0;
            min_lo_q <= 4'd0;
            sec_hi_q <= 4'd0;
            sec_lo_q <= 4'd0;
            fmt12_q  <= DEFAULT_12H;
            sec_tick <= 1'b0;
            digit_en <= 6'b111111;
        end else begin
            st_q     <= st_nx;
            blink_q  <= blink_nx;
            digit_en <= en_nx;
            sec_tick <= tick;
            if (fmt_btn)
                fmt12_q <= ~fmt12_q;
            case (st_q)
                RUN: begin
                    presc_q <= (tick || mode_btn) ? '0 : presc_q + CW'(1);
                    if (tick) begin
                        {sec_hi_q, sec_lo_q} <= sec_nx[7:0];
                        if (sec_nx[8]) begin
                            {min_hi_q, min_lo_q} <= min_nx[7:0];
                            if (min_nx[8])
                                {hrs_hi_q, hrs_lo_q} <= hrs_nx;
                        end
                    end
                end
                SET_HR: begin
                    presc_q <= '0;
                    if (!mode_btn && inc_btn)
                        {hrs_hi_q, hrs_lo_q} <= hrs_nx;
                end
                SET_MIN: begin
                    presc_q <= '0;
                    if (mode_btn)
                        {sec_hi_q, sec_lo_q} <= 8'h00;
                    else if (inc_btn)
                        {min_hi_q, min_lo_q} <= min_nx[7:0];
                end
                default: presc_q <= '0;
            endcase
        end
    end

    // 12-hour display mapping done in BCD without arithmetic on the full hour
    always_comb begin
        is_pm  = (hrs_hi_q == 4'd2) || (hrs_hi_q == 4'd1 && hrs_lo_q >= 4'd2);
        hrs_hi = hrs_hi_q;
        hrs_lo = hrs_lo_q;
        pm     = 1'b0;
        if (fmt12_q) begin
            pm = is_pm;
            if (hrs_hi_q == 4'd0 && hrs_lo_q == 4'd0) begin
                hrs_hi = 4'd1;
                hrs_lo = 4'd2;
            end else if (hrs_hi_q == 4'd1 && hrs_lo_q > 4'd2) begin
                hrs_hi = 4'd0;
                hrs_lo = hrs_lo_q - 4'd2;
            end else if (hrs_hi_q == 4'd2 && hrs_lo_q < 4'd2) begin
                hrs_hi = 4'd0;
                hrs_lo = hrs_lo_q + 4'd8;
            end else if (hrs_hi_q == 4'd2) begin
                hrs_hi = 4'd1;
                hrs_lo = hrs_lo_q - 4'd2;
            end
        end
    end

    assign min_hi = min_hi_q;
    assign min_lo = min_lo_q;
    assign sec_hi = sec_hi_q;
    assign sec_lo = sec_lo_q;
    assign state  = st_q;

endmodule
